// File: rtl/dark_channel_3x3.sv
// Dark-channel stage: per-pixel min(R,G,B) followed by a 3x3 spatial min.
// Two line buffers plus a 3x3 window; border masks replace out-of-image taps.
module dark_channel_3x3 #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_sof,
   input  logic [7:0] R,
   input  logic [7:0] G,
   input  logic [7:0] B,
   output logic       in_ready,
   output logic [7:0] I_dark,
   output logic       out_valid,
   output logic       out_eof
);

   localparam int AW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT + 2);
   localparam int FW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] ocol_q, ocol_d;
   logic [RW-1:0] orow_q, orow_d;
   logic [FW-1:0] fcnt_q, fcnt_d;

   // win[col][row]: col 2 is newest, row 2 is the bottom tap
   logic [2:0][2:0][7:0] win_q, win_d;

   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic       out_eof_q, out_eof_d;
   logic [7:0] i_dark_q, i_dark_d;

   logic [7:0] lb0_q [WIDTH];
   logic [7:0] lb1_q [WIDTH];

   logic          accept;
   logic          restart;
   logic          step;
   logic          emit;
   logic          last_pix;
   logic [AW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic [7:0]    m;
   logic [7:0]    lb0_rd;
   logic [7:0]    lb1_rd;
   logic [7:0]    minv;
   logic          vl, vr, vt, vb;

   function automatic logic [7:0] min2(input logic [7:0] a,
                                       input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   // Next-state logic: pixel/flush stepping, window shift, masked min, FSM
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      ocol_d      = ocol_q;
      orow_d      = orow_q;
      fcnt_d      = fcnt_q;
      win_d       = win_q;
      out_valid_d = 1'b0;
      out_eof_d   = 1'b0;
      i_dark_d    = i_dark_q;
      minv        = 8'hFF;

      m       = min2(min2(R, G), B);
      accept  = in_valid & in_ready_q;
      restart = accept & in_sof & (state_q != S_FLUSH);

      unique case (state_q)
         S_IDLE:  step = restart;
         S_RUN:   step = accept;
         S_FLUSH: step = 1'b1;
         default: step = 1'b0;
      endcase

      // A restarting pixel is always index 0 of the new frame
      cur_col = restart ? '0 : col_q;
      cur_row = restart ? '0 : row_q;
      lb0_rd  = lb0_q[cur_col];
      lb1_rd  = lb1_q[cur_col];

      last_pix = (cur_row == RW'(HEIGHT - 1)) &&
                 (cur_col == AW'(WIDTH - 1));

      // Output k is ready once index k+WIDTH+1 has been stepped
      emit = step &&
             ((cur_row >= RW'(2)) ||
              ((cur_row == RW'(1)) && (cur_col != '0)));

      if (restart) begin
         ocol_d = '0;
         orow_d = '0;
      end

      if (step) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = {m, lb1_rd, lb0_rd};
         row_d    = cur_row;
         if (cur_col == AW'(WIDTH - 1)) begin
            col_d = '0;
            row_d = cur_row + RW'(1);
         end else begin
            col_d = cur_col + AW'(1);
         end
      end

      vl = (ocol_q != '0);
      vr = (ocol_q != AW'(WIDTH - 1));
      vt = (orow_q != '0);
      vb = (orow_q != RW'(HEIGHT - 1));

      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < 3; r++) begin
            if ((c != 0 || vl) && (c != 2 || vr) &&
                (r != 0 || vt) && (r != 2 || vb)) begin
               minv = min2(minv, win_d[c][r]);
            end
         end
      end

      if (emit) begin
         out_valid_d = 1'b1;
         i_dark_d    = minv;
         out_eof_d   = (orow_q == RW'(HEIGHT - 1)) &&
                       (ocol_q == AW'(WIDTH - 1));
         if (ocol_q == AW'(WIDTH - 1)) begin
            ocol_d = '0;
            orow_d = orow_q + RW'(1);
         end else begin
            ocol_d = ocol_q + AW'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (restart) state_d = S_RUN;
         end
         S_RUN: begin
            if (accept && !in_sof && last_pix) begin
               state_d = S_FLUSH;
               fcnt_d  = '0;
            end
         end
         S_FLUSH: begin
            fcnt_d = fcnt_q + FW'(1);
            if (fcnt_q == FW'(WIDTH)) begin
               state_d = S_IDLE;
               fcnt_d  = '0;
               col_d   = '0;
               row_d   = '0;
               ocol_d  = '0;
               orow_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d != S_FLUSH);
   end

   // State, counters, window and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         ocol_q      <= '0;
         orow_q      <= '0;
         fcnt_q      <= '0;
         win_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_eof_q   <= 1'b0;
         i_dark_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         ocol_q      <= ocol_d;
         orow_q      <= orow_d;
         fcnt_q      <= fcnt_d;
         win_q       <= win_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_eof_q   <= out_eof_d;
         i_dark_q    <= i_dark_d;
      end
   end

   // Line buffers: lb1 holds the previous line, lb0 the one before it
   always_ff @(posedge clk) begin
      if (step) begin
         lb0_q[cur_col] <= lb1_rd;
         lb1_q[cur_col] <= m;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_eof   = out_eof_q;
   assign I_dark    = i_dark_q;

endmodule

// File: tb/tb_dark_channel_3x3.sv
// Scoreboard bench for dark_channel_3x3 at WIDTH=4, HEIGHT=3.
// Expected outputs are queued at stimulus time and popped by a monitor.
module tb_dark_channel_3x3;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] R, G, B;
   logic       in_ready;
   logic [7:0] I_dark;
   logic       out_valid;
   logic       out_eof;

   dark_channel_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_sof   (in_sof),
      .R        (R),
      .G        (G),
      .B        (B),
      .in_ready (in_ready),
      .I_dark   (I_dark),
      .out_valid(out_valid),
      .out_eof  (out_eof)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] exp_q[$];
   logic [7:0] fr[N];
   logic [7:0] fg[N];
   logic [7:0] fb[N];

   int  acc_cyc;
   int  t0;
   bit  track = 1'b0;
   int  first_ov = -1;
   int  eof_cyc = -1;
   int  rl_n = 0;
   int  rl_first = -1;
   int  ov_cnt = 0;
   int  eof_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: pop one expectation per output beat
   always @(negedge clk) begin
      logic [8:0] e;
      if (out_valid) begin
         ov_cnt++;
         if (out_eof) eof_cnt++;
         if (track && first_ov < 0) first_ov = cyc;
         if (track && out_eof) eof_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got I_dark=%0d eof=%0d expected none",
                     I_dark, out_eof);
         end else begin
            e = exp_q.pop_front();
            check("I_dark", int'(I_dark), int'(e[7:0]));
            check("out_eof", int'(out_eof), int'(e[8]));
         end
      end
      if (track && !in_ready) begin
         rl_n++;
         if (rl_first < 0) rl_first = cyc;
      end
   end

   function automatic logic [7:0] mval(input int i);
      logic [7:0] t;
      t = (fr[i] < fg[i]) ? fr[i] : fg[i];
      return (t < fb[i]) ? t : fb[i];
   endfunction

   // Reference: plain neighbourhood min over in-image positions
   function automatic logic [7:0] ref_out(input int k);
      logic [7:0] acc;
      int r, c;
      r = k / W;
      c = k % W;
      acc = 8'hFF;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
               if (mval((r + dr) * W + c + dc) < acc)
                  acc = mval((r + dr) * W + c + dc);
      return acc;
   endfunction

   task automatic push_ref(input int first, input int last);
      for (int k = first; k <= last; k++)
         exp_q.push_back({(k == N - 1) ? 1'b1 : 1'b0, ref_out(k)});
   endtask

   task automatic send(input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit sof);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      R        = r;
      G        = g;
      B        = b;
      in_sof   = sof;
      in_valid = 1'b1;
      acc_cyc  = cyc;
      @(negedge clk);
   endtask

   task automatic send_frame(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         send(fr[i], fg[i], fb[i], i == 0);
         if (i == 0) t0 = acc_cyc;
         if (gaps && i < N - 1 && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(2, 1)) begin
               @(negedge clk);
               check("gap_quiet", int'(out_valid), 0);
            end
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
      check("ready_after", int'(in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ov0, eof0;
      logic [7:0] exp2[N];
      exp2 = '{30, 30, 30, 200, 30, 30, 30, 200, 30, 30, 30, 200};
      rst = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      R = 8'd0;
      G = 8'd0;
      B = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_eof", int'(out_eof), 0);
      check("rst_I_dark", int'(I_dark), 0);
      check("rst_in_ready", int'(in_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // Constant frame plus latency/flush timing
      for (int i = 0; i < N; i++) begin
         fr[i] = 8'd100; fg[i] = 8'd100; fb[i] = 8'd100;
      end
      for (int k = 0; k < N; k++)
         exp_q.push_back({(k == N - 1) ? 1'b1 : 1'b0, 8'd100});
      track = 1'b1;
      send_frame(N, 1'b0);
      drain();
      track = 1'b0;
      check("lat_first_out", first_ov - t0, 6);
      check("lat_eof", eof_cyc - t0, 17);
      check("ready_low_cycles", rl_n, 5);
      check("ready_low_start", rl_first - t0, 12);

      // Single dark pixel at (1,1)
      for (int i = 0; i < N; i++) begin
         fr[i] = 8'd200; fg[i] = 8'd200; fb[i] = 8'd200;
      end
      fr[5] = 8'd50; fg[5] = 8'd30; fb[5] = 8'd90;
      for (int k = 0; k < N; k++)
         exp_q.push_back({(k == N - 1) ? 1'b1 : 1'b0, exp2[k]});
      send_frame(N, 1'b0);
      drain();

      // Varied frame with input gaps
      for (int i = 0; i < N; i++) begin
         fr[i] = 8'(37 * i + 11);
         fg[i] = 8'(91 * i + 200);
         fb[i] = 8'(13 * i + 60);
      end
      push_ref(0, N - 1);
      send_frame(N, 1'b1);
      drain();

      // Dropped pixel in IDLE, then abort at index 7
      ov0 = ov_cnt;
      send(8'd10, 8'd10, 8'd10, 1'b0);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("idle_drop", ov_cnt - ov0, 0);
      eof0 = eof_cnt;
      for (int i = 0; i < N; i++) begin
         fr[i] = 8'(250 - 19 * i);
         fg[i] = 8'(17 * i + 3);
         fb[i] = 8'(120 + 5 * i);
      end
      for (int k = 0; k < 2; k++) exp_q.push_back({1'b0, ref_out(k)});
      send_frame(7, 1'b0);
      for (int i = 0; i < N; i++) begin
         fr[i] = 8'(60 + 7 * i);
         fg[i] = 8'(200 - 11 * i);
         fb[i] = 8'(29 * i + 40);
      end
      push_ref(0, N - 1);
      send_frame(N, 1'b0);
      drain();
      check("abort_eof_count", eof_cnt - eof0, 1);

      // Reset during flush
      for (int i = 0; i < N; i++) begin
         fr[i] = 8'(77 + i); fg[i] = 8'd90; fb[i] = 8'd250;
      end
      push_ref(0, N - 1);
      send_frame(N, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_flush_valid", int'(out_valid), 0);
      check("rst_flush_ready", int'(in_ready), 1);
      check("rst_flush_eof", int'(out_eof), 0);
      #1;
      check("rst_flush_pending", exp_q.size(), 4);
      exp_q.delete();
      ov0 = ov_cnt;
      repeat (8) @(negedge clk);
      check("rst_flush_quiet", ov_cnt - ov0, 0);

      for (int i = 0; i < N; i++) begin
         fr[i] = 8'(5 + 21 * i);
         fg[i] = 8'(240 - 3 * i);
         fb[i] = 8'(33 * i + 9);
      end
      push_ref(0, N - 1);
      send_frame(N, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dark_channel_3x3.md
# dark_channel_3x3

Streaming dark-channel stage of the haze-removal pipeline. Takes raster-order RGB pixels, forms the per-pixel minimum of R, G and B, then applies a 3x3 spatial minimum filter using two on-chip line buffers. Produces the 8-bit `I_dark` stream consumed by the local atmospheric light and transmission stages. The output is frame-aligned in raster order, and an end-of-frame flush drains the filter window.

## Interface
- `WIDTH`, default 640: pixels per line, must be ≥ 3.
- `HEIGHT`, default 480: lines per frame, must be ≥ 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input pixel present.
- `in_sof` input 1: marks the first pixel of a frame. Only meaningful when `in_valid` is high.
- `R`, `G`, `B` input 8 each: pixel channels.
- `in_ready` output 1: block accepts a pixel this cycle. A pixel is accepted when `in_valid` and `in_ready` are both high.
- `I_dark` output 8: dark-channel value.
- `out_valid` output 1: `I_dark` is valid this cycle. There is no output backpressure; downstream always accepts.
- `out_eof` output 1: high with the last pixel of the frame, index WIDTH*HEIGHT-1.

## Operation
- Pixel index k = r*WIDTH + c, with r the line and c the column. N = WIDTH*HEIGHT.
- m(r,c) = min(R,G,B) of the accepted pixel.
- `I_dark`(r,c) = minimum of m over rows r-1..r+1 and columns c-1..c+1, counting only positions inside the image.
  - Out-of-image neighbours are treated as 255, so they never win the minimum.
  - Borders and corners therefore use 2x2 or 2x3 windows.
- Storage: two line buffers of WIDTH x 8 bits hold m for the previous two lines, plus a 3x3 window register array. Column and row counters drive the border masks.
- State machine, with all transitions on the clock edge:
  - IDLE: `in_ready`=1. Pixels accepted without `in_sof` are dropped. An accepted pixel with `in_sof` becomes index 0 and the state moves to RUN.
  - RUN: `in_ready`=1. Each accepted pixel advances k. Accepting index N-1 moves the state to FLUSH.
  - FLUSH: `in_ready`=0 for exactly WIDTH+1 cycles. Each cycle injects one virtual pixel, the filter treats it as out-of-image, and it advances the output pipeline. After the last flush step the state returns to IDLE.
- `in_sof` accepted while in RUN aborts the current frame:
  - Pending outputs are discarded and no `out_eof` is produced.
  - That pixel restarts the frame as index 0.
  - No output is emitted for the aborted frame after the abort cycle.
- `in_valid` low in RUN stalls the pipeline. Counters and window hold their values and no output is produced.
- Arithmetic: 8-bit unsigned comparisons only. No widening.

## Timing
- Fixed structural delay: output k is produced by the acceptance of index k+WIDTH+1, or by the corresponding flush step.
- `out_valid` and `I_dark` are registered and appear one cycle after the triggering acceptance or flush step.
- If index N-1 is accepted at cycle t:
  - Flush steps occur at t+1 .. t+WIDTH+1.
  - Outputs N-WIDTH-1 .. N-1 appear at t+2 .. t+WIDTH+2.
  - `out_eof` is high at t+WIDTH+2.
  - `in_ready` returns high at t+WIDTH+2.
- Output gaps mirror input gaps while in RUN. Flush outputs are back-to-back.
- Reset values, applied on the cycle after `rst` is sampled high:
  - `out_valid`=0, `out_eof`=0, `I_dark`=0.
  - `in_ready`=1, state IDLE, counters 0.
  - Line-buffer contents are don't-care; the border masks make them irrelevant.
- Reset mid-frame or mid-flush takes effect on the next edge and no further outputs are produced.
- `rst` has priority over every other input.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3 unless stated.
- Constant frame R=G=B=100, `in_valid` held high → 12 outputs, all `I_dark`=100; `out_eof` only on the 12th output; `in_ready` low for exactly 5 cycles after the last input.
- Single pixel R=50,G=30,B=90 at (1,1), all others R=G=B=200 → outputs at columns 0–2 equal 30 on all rows; column 3 equals 200.
- Latency: first pixel accepted at cycle 0, continuous input → first `out_valid` at cycle 6; `out_eof` at cycle 17; `in_ready` low at cycles 12–16.
- Random `in_valid` gaps (≈50% duty) on a random frame → output sequence identical to a reference-model 3x3 min filter; no output during gaps while in RUN.
- `in_sof` reasserted at input index 7 → no `out_eof` for the aborted frame; the new frame's output 0 is triggered by its own index 5 acceptance; a pixel without `in_sof` in IDLE is dropped with no output.
- `rst` asserted during FLUSH → `out_valid` 0 from the next cycle; `in_ready`=1; a following full frame produces correct results.
